// File: rtl/ft_sync_rx_if.sv
// Bus bundle for the FT2232H synchronous-FIFO receive path.
// The rx_count port exists only when FT_SYNC_RX_STATS_EN is defined.
interface ft_sync_rx_if;
  logic       rxf;
  logic [7:0] data;
  logic       oe;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overflow;
`ifdef FT_SYNC_RX_STATS_EN
  logic [15:0] rx_count;
`endif

  modport master (
    input  rxf, data, rx_ready,
`ifdef FT_SYNC_RX_STATS_EN
    output rx_count,
`endif
    output oe, rd, rx_data, rx_valid, overflow
  );

  modport slave (
    output rxf, data, rx_ready,
`ifdef FT_SYNC_RX_STATS_EN
    input  rx_count,
`endif
    input  oe, rd, rx_data, rx_valid, overflow
  );
endinterface

// File: rtl/ft_sync_rx.sv
// FT2232H synchronous-FIFO read engine feeding a small receive FIFO.
// Optional accepted-byte counter on rx_count when FT_SYNC_RX_STATS_EN is defined.
module ft_sync_rx #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HEADROOM = 2
) (
  input  logic         comm_clk,
  input  logic         rst,
  ft_sync_rx_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C    = PW'(DEPTH);
  localparam logic [PW-1:0] HEADROOM_C = PW'(HEADROOM);

  typedef enum logic [1:0] {IDLE, TURN, READ} state_e;

  state_e        state_q;
  logic          oe_q;
  logic          rd_q;
  logic          overflow_q;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level, level_after, free_now, free_after;
  logic          empty, full, accept, push, pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level  = wr_ptr_q - rd_ptr_q;

  // The device drives a byte on every edge where both strobes and RXF# are low.
  assign accept = !oe_q && !rd_q && !bus.rxf;
  assign pop    = !empty && bus.rx_ready;
  assign push   = accept && (!full || pop);

  assign level_after = level + PW'(push) - PW'(pop);
  assign free_now    = DEPTH_C - level;
  assign free_after  = DEPTH_C - level_after;

  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge comm_clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (accept && full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge comm_clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= bus.data;
  end

  // Strobes are registered so oe and rd always leave READ together.
  always_ff @(posedge comm_clk) begin
    if (rst) begin
      state_q <= IDLE;
      oe_q    <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.rxf && (free_now >= HEADROOM_C)) begin
            state_q <= TURN;
            oe_q    <= 1'b0;
            rd_q    <= 1'b1;
          end
        end
        TURN: begin
          state_q <= READ;
          oe_q    <= 1'b0;
          rd_q    <= 1'b0;
        end
        READ: begin
          if (bus.rxf || (free_after < HEADROOM_C)) begin
            state_q <= IDLE;
            oe_q    <= 1'b1;
            rd_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b1;
          rd_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.oe       = oe_q;
  assign bus.rd       = rd_q;
  assign bus.rx_valid = !empty;
  assign bus.rx_data  = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
  assign bus.overflow = overflow_q;

`ifdef FT_SYNC_RX_STATS_EN
  logic [15:0] rx_count_q;

  // Counts every accepted byte, including ones dropped on overflow.
  always_ff @(posedge comm_clk) begin
    if (rst)         rx_count_q <= '0;
    else if (accept) rx_count_q <= rx_count_q + 16'd1;
  end

  assign bus.rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_ft_sync_rx.sv
// Scoreboard bench for ft_sync_rx: device model plus consumer on the main
// instance, and a zero-headroom instance for the full/overflow corner.
`timescale 1ns/1ps
module tb_ft_sync_rx;

  logic comm_clk = 1'b0;
  logic rst      = 1'b1;
  always #5 comm_clk = ~comm_clk;

  ft_sync_rx_if bus  ();
  ft_sync_rx_if obus ();

  ft_sync_rx #(.DEPTH(16), .HEADROOM(2)) u_dut (
    .comm_clk (comm_clk),
    .rst      (rst),
    .bus      (bus)
  );

  ft_sync_rx #(.DEPTH(4), .HEADROOM(0)) u_ovf (
    .comm_clk (comm_clk),
    .rst      (rst),
    .bus      (obus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device model and consumer state
  logic [7:0]  exp_q [$];
  logic [7:0]  dev_byte    = 8'h00;
  int          dev_remaining = 0;
  bit          dev_random  = 1'b0;
  bit          gate        = 1'b1;
  int          gate_left   = 0;
  int          ready_mode  = 1;
  int          cyc         = 0;
  int          acc_total   = 0;
  int          pop_total   = 0;
  int          first_acc   = -1;
  int          last_acc    = -1;
  logic [15:0] exp_count   = 16'h0000;

  // Inputs change and outputs are sampled on the falling edge.
  always @(negedge comm_clk) begin
    logic acc;
    logic pop;
    cyc++;
    if (rst) begin
      exp_q.delete();
      dev_remaining = 0;
      exp_count     = 16'h0000;
      bus.rxf       = 1'b1;
      bus.rx_ready  = 1'b0;
    end else begin
      if (dev_random) begin
        if (gate_left <= 0) begin
          gate      = !gate;
          gate_left = int'($urandom_range(25, 1));
        end
        gate_left--;
      end else begin
        gate = 1'b1;
      end
      bus.rxf  = !(gate && dev_remaining > 0);
      bus.data = bus.rxf ? ~dev_byte : dev_byte;
      case (ready_mode)
        0:       bus.rx_ready = 1'b0;
        1:       bus.rx_ready = 1'b1;
        default: bus.rx_ready = 1'($urandom_range(1, 0));
      endcase

      check("oe_rd_legal", 32'({bus.oe, bus.rd} == 2'b10), 0);
      check("rx_valid", 32'(bus.rx_valid), 32'(exp_q.size() != 0));
      check("overflow_clear", 32'(bus.overflow), 0);

      pop = bus.rx_valid && bus.rx_ready;
      if (pop) begin
        pop_total++;
        if (exp_q.size() > 0) check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end

      acc = !bus.oe && !bus.rd && !bus.rxf;
      if (acc) begin
        exp_q.push_back(bus.data);
        acc_total++;
        exp_count = exp_count + 16'd1;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        dev_remaining--;
        dev_byte = dev_random ? 8'($urandom) : dev_byte + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge comm_clk);
    #2;
  endtask

  task automatic settle(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && dev_remaining == 0 && bus.oe && bus.rd) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, n;
    logic [7:0] drain_exp [4];

    obus.rxf = 1'b1; obus.data = 8'h00; obus.rx_ready = 1'b0;
    bus.rxf  = 1'b1; bus.data  = 8'h00; bus.rx_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_oe", 32'(bus.oe), 1);
    check("rst_rd", 32'(bus.rd), 1);
    check("rst_valid", 32'(bus.rx_valid), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_ovf_inst_valid", 32'(obus.rx_valid), 0);
`ifdef FT_SYNC_RX_STATS_EN
    check("rst_rx_count", 32'(bus.rx_count), 0);
`endif
    rst = 1'b0;

    // Single byte A5
    dev_byte = 8'hA5; dev_remaining = 1; ready_mode = 1;
    step(); check("single_oe_fall", 32'({bus.oe, bus.rd}), 32'b01);
    step(); check("single_rd_fall", 32'({bus.oe, bus.rd}), 32'b00);
    step(); check("single_valid", 32'(bus.rx_valid), 1);
            check("single_data", 32'(bus.rx_data), 32'hA5);
    step(); check("single_strobes_idle", 32'({bus.oe, bus.rd}), 32'b11);
            check("single_popped", 32'(bus.rx_valid), 0);

    // Burst 0x00..0x0F with a consumer popping every cycle
    a0 = acc_total; p0 = pop_total; first_acc = -1;
    dev_byte = 8'h00; dev_remaining = 16; ready_mode = 1;
    settle("burst_done", 100);
    check("burst_accepted", 32'(acc_total - a0), 16);
    check("burst_popped", 32'(pop_total - p0), 16);
    check("burst_back_to_back", 32'(last_acc - first_acc), 15);
`ifdef FT_SYNC_RX_STATS_EN
    check("burst_rx_count", 32'(bus.rx_count), 32'(exp_count));
`endif

    // Backpressure: consumer stalls, engine must stop on headroom
    a0 = acc_total;
    dev_byte = 8'h40; dev_remaining = 40; ready_mode = 0;
    repeat (40) step();
    check("bp_rd_high", 32'(bus.rd), 1);
    check("bp_oe_high", 32'(bus.oe), 1);
    check("bp_level_ge14", 32'(exp_q.size() >= 14), 1);
    check("bp_level_le_depth", 32'(exp_q.size() <= 16), 1);
    ready_mode = 1;
    settle("bp_resume", 300);
    check("bp_all_accepted", 32'(acc_total - a0), 40);

    // Random RXF# gating and random consumer
    a0 = acc_total; p0 = pop_total;
    gate = 1'b0; gate_left = 0; dev_remaining = 1_000_000; ready_mode = 2; dev_random = 1'b1;
    repeat (10000) step();
    dev_random = 1'b0; dev_remaining = 0; ready_mode = 1;
    settle("rand_drain", 300);
    check("rand_no_loss", 32'(pop_total - p0), 32'(acc_total - a0));
    check("rand_traffic", 32'(acc_total - a0 > 100), 1);
`ifdef FT_SYNC_RX_STATS_EN
    check("rand_rx_count", 32'(bus.rx_count), 32'(exp_count));
`endif

    // Reset during READ
    dev_byte = 8'h90; dev_remaining = 10; ready_mode = 0;
    n = 0;
    while (bus.rd && n < 20) begin step(); n++; end
    check("rst_reach_read", 32'(bus.rd), 0);
    step();
    rst = 1'b1;
    step();
    check("midrst_oe", 32'(bus.oe), 1);
    check("midrst_rd", 32'(bus.rd), 1);
    check("midrst_valid", 32'(bus.rx_valid), 0);
    check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
`ifdef FT_SYNC_RX_STATS_EN
    check("midrst_rx_count", 32'(bus.rx_count), 0);
`endif
    rst = 1'b0;
    repeat (5) step();

    // Full FIFO corner on the zero-headroom instance
    obus.data = 8'h50; obus.rx_ready = 1'b0; obus.rxf = 1'b0;
    n = 0;
    while (obus.rd && n < 10) begin step(); n++; end
    check("ovf_reach_read", 32'(obus.rd), 0);
    for (int k = 0; k < 4; k++) begin
      obus.data = 8'h50 + 8'(k);
      step();
    end
    check("ovf_full_valid", 32'(obus.rx_valid), 1);
    check("ovf_full_no_flag", 32'(obus.overflow), 0);
    check("ovf_full_head", 32'(obus.rx_data), 32'h50);
    obus.data = 8'h54; obus.rx_ready = 1'b1;
    step();
    check("ovf_simul_no_flag", 32'(obus.overflow), 0);
    check("ovf_simul_head", 32'(obus.rx_data), 32'h51);
    obus.data = 8'h55; obus.rx_ready = 1'b0;
    step();
    check("ovf_flag_set", 32'(obus.overflow), 1);
    obus.rxf = 1'b1;
    repeat (5) step();
    check("ovf_sticky", 32'(obus.overflow), 1);
`ifdef FT_SYNC_RX_STATS_EN
    check("ovf_rx_count", 32'(obus.rx_count), 6);
`endif
    drain_exp = '{8'h51, 8'h52, 8'h53, 8'h54};
    obus.rx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_valid", 32'(obus.rx_valid), 1);
      check("ovf_drain_data", 32'(obus.rx_data), 32'(drain_exp[k]));
      step();
    end
    check("ovf_drain_empty", 32'(obus.rx_valid), 0);
    check("ovf_still_set", 32'(obus.overflow), 1);
    rst = 1'b1;
    step();
    check("ovf_cleared_by_rst", 32'(obus.overflow), 0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft_sync_rx.md
FT_SYNC_RX -- requirements
Module: ft_sync_rx

Interface
REQ-001 Parameter DEPTH, default 16, internal receive FIFO depth in bytes; power of two, minimum 4.
REQ-002 Parameter HEADROOM, default 2, minimum free FIFO entries required to start or continue a read burst.
REQ-003 comm_clk  input  1  60 MHz clock from FT2232H; the only clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rxf  input  1  FT2232H RXF#, active-low; low means the device holds at least one byte for the FPGA.
REQ-006 data  input  8  FT2232H data bus, read direction; pad tristate is handled outside this block.
REQ-007 oe  output  1  FT2232H OE#, active-low; low asks the device to drive data.
REQ-008 rd  output  1  FT2232H RD#, active-low; low together with oe low and rxf low transfers one byte per edge.
REQ-009 rx_data  output  8  byte at the head of the internal FIFO.
REQ-010 rx_valid  output  1  high when the FIFO is not empty.
REQ-011 rx_ready  input  1  consumer accept; a pop happens when rx_valid and rx_ready are both high at an edge.
REQ-012 overflow  output  1  sticky error flag; set if a byte is accepted while the FIFO is full.

Function
REQ-013 oe and rd shall be registered outputs driven by an FSM with states IDLE, TURN and READ.
REQ-014 IDLE: oe=1, rd=1. Go to TURN when rxf==0 and free entries >= HEADROOM.
REQ-015 TURN: oe=0, rd=1, lasting exactly one cycle for bus turnaround. Go to READ.
REQ-016 READ: oe=0, rd=0. Go to IDLE when rxf==1, or when free entries after this edge's push/pop < HEADROOM.
REQ-017 Byte accept: at any edge with sampled rd==0, oe==0 and rxf==0, data shall be pushed into the FIFO that cycle.
REQ-018 No byte shall be pushed while oe==1 or rd==1.
REQ-019 Leaving READ shall return oe and rd to 1 together on the next edge; no state holds oe=1 with rd=0.
REQ-020 Sustained throughput shall be one byte per comm_clk while rxf==0, space is available and the consumer pops each cycle.
REQ-021 FIFO: the pointer is one bit wider than log2(DEPTH); full and empty are decided from the MSB. Pointers wrap modulo 2*DEPTH.
REQ-022 A push and a pop in the same cycle shall leave the occupancy unchanged; this is legal when the FIFO is full.
REQ-023 A push while the FIFO is full and no pop occurs shall drop the byte and set overflow. The HEADROOM rule makes this unreachable in correct operation.
REQ-024 Latency: a byte accepted at edge N shall appear on rx_data with rx_valid=1 after edge N, when the FIFO was empty.
REQ-025 rx_data shall hold stable while rx_valid=1 and rx_ready=0.
REQ-026 If rxf rises mid-burst, the byte on that edge shall not be accepted and the FSM shall go to IDLE.

Reset
REQ-027 While rst=1 at an edge: FSM=IDLE, oe=1, rd=1, FIFO empty (rx_valid=0), overflow=0, rx_data=8'h00.
REQ-028 Reset asserted mid-burst shall deassert rd and oe on the same edge; the in-flight byte is discarded.

Configuration
REQ-029 Macro FT_SYNC_RX_STATS_EN: when defined, add output rx_count [15:0] counting accepted bytes. It wraps 16'hFFFF->0, resets to 0, and includes bytes dropped on overflow.
REQ-030 When FT_SYNC_RX_STATS_EN is not defined, the rx_count port and its counter shall be absent; all other behaviour is identical.

Verification
REQ-031 Single byte: rxf=0 for one byte holding 8'hA5, rx_ready=1 -> oe falls, one cycle later rd falls; rx_data=8'hA5 with rx_valid=1 for one pop; oe and rd return to 1.
REQ-032 Burst: 16 bytes 0x00..0x0F, rxf=0 throughout, rx_ready=1 -> bytes accepted back-to-back, 1 per cycle, popped in order 0x00..0x0F, overflow=0.
REQ-033 Backpressure: DEPTH=16, rx_ready=0, rxf held 0 -> rd rises when free entries < 2. The FIFO holds 14 or more bytes and overflow stays 0. Set rx_ready=1 -> bursts resume and the data stays in order.
REQ-034 rxf toggles randomly (period 1-25 cycles) for 10000 cycles, rx_ready random -> the popped stream equals the device-side stream, with no loss or duplication.
REQ-035 rst=1 asserted during READ -> next edge oe=1, rd=1, rx_valid=0; with FT_SYNC_RX_STATS_EN defined, rx_count=0.
REQ-036 Full and simultaneous: FIFO full, push and pop on the same edge -> occupancy stays DEPTH, overflow=0; a forced push with no pop -> overflow=1 and stays set until reset.
